mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port (I-cache / D-cache) arbiter in front of a single DDR block port.
// Optional grant counters are compiled in when MEM_ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
  parameter int ADDR_W  = 30,
  parameter int BLOCK_W = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ic_req,
  input  logic [ADDR_W-1:0]  ic_addr,
  output logic               ic_rdy,
  output logic [BLOCK_W-1:0] ic_block,
  input  logic               dc_req,
  input  logic               dc_write,
  input  logic [ADDR_W-1:0]  dc_addr,
  input  logic [BLOCK_W-1:0] dc_wdata,
  output logic               dc_rdy,
  output logic [BLOCK_W-1:0] dc_block,
  output logic               ram_en,
  output logic               ram_write,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [BLOCK_W-1:0] ram_wdata,
  input  logic               ram_rdy,
  input  logic [BLOCK_W-1:0] ram_block,
  output logic               busy
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]        ic_grant_cnt,
  output logic [31:0]        dc_grant_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_reg, state_next;
  logic                 owner_reg, owner_next;            // 0 = I-cache, 1 = D-cache
  logic                 last_grant_reg, last_grant_next;
  logic                 ram_en_reg, ram_en_next;
  logic                 ram_write_reg, ram_write_next;
  logic [ADDR_W-1:0]    ram_addr_reg, ram_addr_next;
  logic [BLOCK_W-1:0]   ram_wdata_reg, ram_wdata_next;
  logic [BLOCK_W-1:0]   ic_block_reg, ic_block_next;
  logic [BLOCK_W-1:0]   dc_block_reg, dc_block_next;
  logic                 ic_rdy_reg, ic_rdy_next;
  logic                 dc_rdy_reg, dc_rdy_next;
  logic                 busy_reg, busy_next;
  logic                 pick_dc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b0;
      ram_en_reg     <= 1'b0;
      ram_write_reg  <= 1'b0;
      ram_addr_reg   <= '0;
      ram_wdata_reg  <= '0;
      ic_block_reg   <= '0;
      dc_block_reg   <= '0;
      ic_rdy_reg     <= 1'b0;
      dc_rdy_reg     <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      ram_en_reg     <= ram_en_next;
      ram_write_reg  <= ram_write_next;
      ram_addr_reg   <= ram_addr_next;
      ram_wdata_reg  <= ram_wdata_next;
      ic_block_reg   <= ic_block_next;
      dc_block_reg   <= dc_block_next;
      ic_rdy_reg     <= ic_rdy_next;
      dc_rdy_reg     <= dc_rdy_next;
      busy_reg       <= busy_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    ram_en_next     = ram_en_reg;
    ram_write_next  = ram_write_reg;
    ram_addr_next   = ram_addr_reg;
    ram_wdata_next  = ram_wdata_reg;
    ic_block_next   = ic_block_reg;
    dc_block_next   = dc_block_reg;
    ic_rdy_next     = 1'b0;
    dc_rdy_next     = 1'b0;
    // On a tie the D-cache wins unless it was the last one served.
    pick_dc         = dc_req && (!ic_req || !last_grant_reg);

    case (state_reg)
      IDLE: begin
        if (ic_req || dc_req) begin
          owner_next     = pick_dc;
          ram_en_next    = 1'b1;
          ram_write_next = pick_dc & dc_write;
          ram_addr_next  = pick_dc ? dc_addr : ic_addr;
          ram_wdata_next = pick_dc ? dc_wdata : '0;
          state_next     = BUSY;
        end
      end
      BUSY: begin
        if (ram_rdy) begin
          ram_en_next = 1'b0;
          state_next  = DONE;
          if (owner_reg) begin
            dc_rdy_next = 1'b1;
            // A writeback returns nothing, so the D-cache block is left alone.
            if (!ram_write_reg) dc_block_next = ram_block;
          end else begin
            ic_rdy_next   = 1'b1;
            ic_block_next = ram_block;
          end
        end
      end
      DONE: begin
        last_grant_next = owner_reg;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  assign ic_rdy    = ic_rdy_reg;
  assign ic_block  = ic_block_reg;
  assign dc_rdy    = dc_rdy_reg;
  assign dc_block  = dc_block_reg;
  assign ram_en    = ram_en_reg;
  assign ram_write = ram_write_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_wdata = ram_wdata_reg;
  assign busy      = busy_reg;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] ic_cnt_reg, dc_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ic_cnt_reg <= '0;
      dc_cnt_reg <= '0;
    end else if (state_reg == DONE) begin
      if (owner_reg) dc_cnt_reg <= dc_cnt_reg + 32'd1;
      else           ic_cnt_reg <= ic_cnt_reg + 32'd1;
    end
  end

  assign ic_grant_cnt = ic_cnt_reg;
  assign dc_grant_cnt = dc_cnt_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants/blocks are queued at
// stimulus time and popped when the owner's rdy pulse appears.
module tb_mem_port_arbiter;

  localparam int AW = 30;
  localparam int BW = 256;

  typedef struct {
    bit            dc;
    bit            wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] block;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req, dc_req, dc_write, ram_rdy;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [BW-1:0] dc_wdata, ram_block;
  logic          ic_rdy, dc_rdy, ram_en, ram_write, busy;
  logic [BW-1:0] ic_block, dc_block, ram_wdata;
  logic [AW-1:0] ram_addr;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0]   ic_grant_cnt, dc_grant_cnt;
`endif

  exp_t          exp_q[$];
  logic [BW-1:0] model_ic_block, model_dc_block;
  int            total = 0;
  int            bad   = 0;

  mem_port_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdy(ic_rdy), .ic_block(ic_block),
    .dc_req(dc_req), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdy(dc_rdy), .dc_block(dc_block),
    .ram_en(ram_en), .ram_write(ram_write), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdy(ram_rdy), .ram_block(ram_block), .busy(busy)
`ifdef MEM_ARB_PERF_CNT_EN
    , .ic_grant_cnt(ic_grant_cnt), .dc_grant_cnt(dc_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    ic_req = 1'b0; dc_req = 1'b0; dc_write = 1'b0; ram_rdy = 1'b0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; ram_block = '0;
    tick();
    tick();
    rst = 1'b0;
    model_ic_block = '0;
    model_dc_block = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (busy !== 1'b0 || ram_en !== 1'b0 || ram_write !== 1'b0 || ic_rdy !== 1'b0 ||
        dc_rdy !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0 ||
        ic_block !== '0 || dc_block !== '0) begin
      bad++;
      $display("FAIL reset_state: busy=%b ram_en=%b ram_write=%b ic_rdy=%b dc_rdy=%b ram_addr=%h, want all zero",
               busy, ram_en, ram_write, ic_rdy, dc_rdy, ram_addr);
    end
    $display("reset: outputs checked after reset");
  endtask

  // One complete transaction with ram_rdy in cycle k of the request.
  task automatic do_txn(input bit is_dc, input bit wr, input logic [AW-1:0] addr,
                        input logic [BW-1:0] wdata, input logic [BW-1:0] blk,
                        input int k, input string name);
    exp_t e;
    e.dc = is_dc; e.wr = wr; e.addr = addr;
    e.block = is_dc ? ((wr) ? model_dc_block : blk) : blk;
    exp_q.push_back(e);
    if (is_dc && !wr) model_dc_block = blk;
    if (!is_dc)       model_ic_block = blk;

    if (is_dc) begin
      dc_req = 1'b1; dc_write = wr; dc_addr = addr; dc_wdata = wdata;
    end else begin
      ic_req = 1'b1; ic_addr = addr;
    end

    for (int i = 1; i <= k; i++) begin
      tick();
      total++;
      if (ram_en !== 1'b1 || ram_addr !== addr || ram_write !== (is_dc & wr) ||
          (wr && ram_wdata !== wdata) || ic_rdy !== 1'b0 || dc_rdy !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL %s_busy_c%0d: ram_en=%b ram_write=%b ram_addr=%h ic_rdy=%b dc_rdy=%b busy=%b, want ram_en=1 ram_write=%b ram_addr=%h rdy=0 busy=1",
                 name, i, ram_en, ram_write, ram_addr, ic_rdy, dc_rdy, busy, is_dc & wr, addr);
      end
      if (i == k) begin
        ram_rdy = 1'b1;
        ram_block = blk;
      end
    end

    tick();
    ram_rdy = 1'b0;
    ram_block = '0;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s_scoreboard: queue empty at rdy", name);
    end else begin
      e = exp_q.pop_front();
      if ((e.dc ? (dc_rdy !== 1'b1 || ic_rdy !== 1'b0 || dc_block !== e.block)
                : (ic_rdy !== 1'b1 || dc_rdy !== 1'b0 || ic_block !== e.block)) || ram_en !== 1'b0) begin
        bad++;
        $display("FAIL %s_done: ic_rdy=%b dc_rdy=%b ram_en=%b block=%h, want owner=%s rdy pulse ram_en=0 block=%h",
                 name, ic_rdy, dc_rdy, ram_en, e.dc ? dc_block : ic_block,
                 e.dc ? "dc" : "ic", e.block);
      end
    end

    if (is_dc) dc_req = 1'b0; else ic_req = 1'b0;
    dc_write = 1'b0;
    tick();
    total++;
    if (ic_rdy !== 1'b0 || dc_rdy !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_after: ic_rdy=%b dc_rdy=%b busy=%b, want 0 0 0", name, ic_rdy, dc_rdy, busy);
    end
    $display("%s: owner=%s write=%0b addr=%h k=%0d", name, is_dc ? "dc" : "ic", wr, addr, k);
  endtask

  task automatic test_single_fill();
    logic [BW-1:0] blk;
    blk = {32{8'hA5}};
    do_txn(1'b0, 1'b0, 30'h100, '0, blk, 5, "single_fill");
  endtask

  task automatic test_stray_rdy();
    ram_rdy = 1'b1;
    ram_block = {32{8'h77}};
    tick();
    ram_rdy = 1'b0;
    ram_block = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (busy !== 1'b0 || ram_en !== 1'b0 || ic_rdy !== 1'b0 || dc_rdy !== 1'b0 ||
          ic_block !== model_ic_block || dc_block !== model_dc_block) begin
        bad++;
        $display("FAIL stray_rdy_c%0d: busy=%b ram_en=%b ic_rdy=%b dc_rdy=%b ic_block=%h, want idle with ic_block=%h",
                 i, busy, ram_en, ic_rdy, dc_rdy, ic_block, model_ic_block);
      end
    end
    $display("stray_rdy: ram_rdy pulsed while idle");
  endtask

  task automatic test_tie();
    exp_t e;
    int   w;
    ic_addr = 30'h200;
    dc_addr = 30'h300;
    dc_write = 1'b0;
    for (int n = 0; n < 4; n++) begin
      e.dc = (n % 2 == 0); e.wr = 1'b0;
      e.addr = e.dc ? 30'h300 : 30'h200;
      e.block = {{31{8'h00}}, 8'(n + 1)} | (e.dc ? {32{8'h20}} : {32{8'h10}});
      exp_q.push_back(e);
    end
    ic_req = 1'b1;
    dc_req = 1'b1;
    for (int n = 0; n < 4; n++) begin
      w = 0;
      while (ram_en !== 1'b1 && w < 20) begin
        tick();
        w++;
      end
      total++;
      if (ram_en !== 1'b1) begin
        bad++;
        $display("FAIL tie_wait_%0d: ram_en=%b after %0d cycles, want 1", n, ram_en, w);
        break;
      end
      e = exp_q.pop_front();
      if (ram_addr !== e.addr) begin
        bad++;
        $display("FAIL tie_order_%0d: ram_addr=%h, want %h (%s)", n, ram_addr, e.addr, e.dc ? "dc" : "ic");
      end
      tick();
      ram_rdy = 1'b1;
      ram_block = e.block;
      tick();
      ram_rdy = 1'b0;
      ram_block = '0;
      if (n == 3) begin
        ic_req = 1'b0;
        dc_req = 1'b0;
      end
      total++;
      if (e.dc ? (dc_rdy !== 1'b1 || ic_rdy !== 1'b0 || dc_block !== e.block)
               : (ic_rdy !== 1'b1 || dc_rdy !== 1'b0 || ic_block !== e.block)) begin
        bad++;
        $display("FAIL tie_done_%0d: ic_rdy=%b dc_rdy=%b, want only %s rdy with block=%h",
                 n, ic_rdy, dc_rdy, e.dc ? "dc" : "ic", e.block);
      end
      if (e.dc) model_dc_block = e.block; else model_ic_block = e.block;
      $display("tie: grant %0d to %s", n, e.dc ? "dc" : "ic");
    end
    tick();
    tick();
    total++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL tie_end: busy=%b queue=%0d, want 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_writeback();
    logic [BW-1:0] wd;
    do_txn(1'b1, 1'b0, 30'h3F00, '0, {32{8'h5A}}, 2, "dc_fill");
    wd = {8{32'h12345678}};
    do_txn(1'b1, 1'b1, 30'h3FF0, wd, {32{8'hEE}}, 3, "writeback");
  endtask

  task automatic test_reset_mid_op();
    ic_req = 1'b1;
    ic_addr = 30'h40;
    tick();
    tick();
    tick();
    rst = 1'b1;
    ic_req = 1'b0;
    tick();
    rst = 1'b0;
    model_ic_block = '0;
    model_dc_block = '0;
    total++;
    if (ram_en !== 1'b0 || busy !== 1'b0 || ic_rdy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_c4: ram_en=%b busy=%b ic_rdy=%b, want 0 0 0", ram_en, busy, ic_rdy);
    end
    tick();
    ram_rdy = 1'b1;
    ram_block = {32{8'hFF}};
    tick();
    ram_rdy = 1'b0;
    ram_block = '0;
    for (int i = 6; i < 8; i++) begin
      total++;
      if (ic_rdy !== 1'b0 || dc_rdy !== 1'b0 || busy !== 1'b0 || ram_en !== 1'b0 || ic_block !== '0) begin
        bad++;
        $display("FAIL midrst_c%0d: ic_rdy=%b dc_rdy=%b busy=%b ram_en=%b ic_block=%h, want idle and zero block",
                 i, ic_rdy, dc_rdy, busy, ram_en, ic_block);
      end
      tick();
    end
    $display("reset_mid_op: reset in busy cycle 3, late ram_rdy in cycle 5");
  endtask

`ifdef MEM_ARB_PERF_CNT_EN
  task automatic test_perf_cnt();
    apply_reset();
    for (int n = 0; n < 3; n++)
      do_txn(1'b0, 1'b0, 30'(32'h500 + n), '0, {32{8'(8'h30 + n)}}, 1 + n, "cnt_ic");
    for (int n = 0; n < 2; n++)
      do_txn(1'b1, 1'b0, 30'(32'h600 + n), '0, {32{8'(8'h40 + n)}}, 2, "cnt_dc");
    total++;
    if (ic_grant_cnt !== 32'd3 || dc_grant_cnt !== 32'd2) begin
      bad++;
      $display("FAIL perf_cnt: ic=%0d dc=%0d, want 3 2", ic_grant_cnt, dc_grant_cnt);
    end
    apply_reset();
    total++;
    if (ic_grant_cnt !== 32'd0 || dc_grant_cnt !== 32'd0) begin
      bad++;
      $display("FAIL perf_cnt_rst: ic=%0d dc=%0d, want 0 0", ic_grant_cnt, dc_grant_cnt);
    end
    $display("perf_cnt: counters checked");
  endtask
`endif

  initial begin
    test_reset();
    test_single_fill();
    test_stray_rdy();
    test_tie();
    test_writeback();
    test_reset_mid_op();
    do_txn(1'b0, 1'b0, 30'h1234, '0, {32{8'h3C}}, 1, "k1_fill");
`ifdef MEM_ARB_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
